// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_entry_ctrl                                             |
// | Purpose  : Assembles two BCD operands from the decoded keypad event      |
// |            stream (digits, ENTER, backspace, clear), with overflow       |
// |            rejection and inactivity timeout, and presents the completed  |
// |            pair downstream over a valid/ready handshake.                 |
// | Ports    : clk, rst_n        clock, async active-low reset               |
// |            i_key_value[3:0]  key code (0-9 digit, A enter, B bksp, C clr)|
// |            i_key_valid       one-cycle strobe qualifying i_key_value     |
// |            o_op_a, o_op_b    latched operands, LSD in [3:0]              |
// |            o_op_valid        operand pair available                      |
// |            i_op_ready        downstream accepts the pair                 |
// |            o_entry_bcd       digits being typed (display)                |
// |            o_entry_count     number of digits in o_entry_bcd             |
// |            o_phase           00 ENTRY_A, 01 ENTRY_B, 10 PRESENT          |
// |            o_err             one-cycle pulse on a rejected key           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module keypad_entry_ctrl #(
   parameter int DIGITS  = 3,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [3:0]                    i_key_value,
   input  logic                          i_key_valid,
   output logic [4*DIGITS-1:0]           o_op_a,
   output logic [4*DIGITS-1:0]           o_op_b,
   output logic                          o_op_valid,
   input  logic                          i_op_ready,
   output logic [4*DIGITS-1:0]           o_entry_bcd,
   output logic [$clog2(DIGITS+1)-1:0]   o_entry_count,
   output logic [1:0]                    o_phase,
   output logic                          o_err
);

   localparam int CW = $clog2(DIGITS + 1);
   // A zero TIMEOUT still gets a 1-bit counter so the declarations stay legal.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] c_FULL = CW'(DIGITS);
   localparam logic [TW-1:0] c_TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_ENTRY_A = 2'b00,
      ST_ENTRY_B = 2'b01,
      ST_PRESENT = 2'b10
   } t_state;

   t_state                r_state;
   logic [4*DIGITS-1:0]   r_entry;
   logic [CW-1:0]         r_count;
   logic [4*DIGITS-1:0]   r_op_a;
   logic [4*DIGITS-1:0]   r_op_b;
   logic                  r_op_valid;
   logic                  r_err;
   logic [TW-1:0]         r_idle;

   logic [4*DIGITS-1:0]   w_shift_in;
   logic [4*DIGITS-1:0]   w_shift_out;
   logic                  w_tmo_en;
   logic                  w_timeout;
   logic                  w_is_digit;
   logic                  w_is_enter;
   logic                  w_is_back;
   logic                  w_is_clear;

   // Digit shift-in (new digit becomes the LSD) and backspace shift-out.
   // A single-digit buffer has no upper digits to keep.
   generate
      if (DIGITS > 1) begin : g_multi_digit
         assign w_shift_in  = {r_entry[4*DIGITS-5:0], i_key_value};
         assign w_shift_out = {4'h0, r_entry[4*DIGITS-1:4]};
      end else begin : g_single_digit
         assign w_shift_in  = i_key_value;
         assign w_shift_out = 4'h0;
      end
   endgenerate

   generate
      if (TIMEOUT > 0) begin : g_timeout_on
         assign w_tmo_en = 1'b1;
      end else begin : g_timeout_off
         assign w_tmo_en = 1'b0;
      end
   endgenerate

   assign w_is_digit = (i_key_value <= 4'd9);
   assign w_is_enter = (i_key_value == 4'hA);
   assign w_is_back  = (i_key_value == 4'hB);
   assign w_is_clear = (i_key_value == 4'hC);

   // A key in the timeout cycle wins; an empty ENTRY_A has nothing to discard.
   assign w_timeout = w_tmo_en && !i_key_valid && (r_state != ST_PRESENT) &&
                      (r_idle == c_TMAX) &&
                      ((r_count != '0) || (r_state == ST_ENTRY_B));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ENTRY_A;
         r_entry    <= '0;
         r_count    <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_valid <= 1'b0;
         r_err      <= 1'b0;
         r_idle     <= '0;
      end else begin
         r_err <= 1'b0;

         // Idle counter saturates at its terminal value in an empty ENTRY_A
         // so it never wraps while nothing is pending.
         if (i_key_valid || (r_state == ST_PRESENT) || w_timeout) begin
            r_idle <= '0;
         end else if (r_idle != c_TMAX) begin
            r_idle <= r_idle + 1'b1;
         end

         if (w_timeout) begin
            r_state <= ST_ENTRY_A;
            r_entry <= '0;
            r_count <= '0;
            r_op_a  <= '0;
         end else if (r_state == ST_PRESENT) begin
            // Handshake takes priority over a simultaneous clear.
            if (r_op_valid && i_op_ready) begin
               r_state    <= ST_ENTRY_A;
               r_op_valid <= 1'b0;
            end else if (i_key_valid && w_is_clear) begin
               r_state    <= ST_ENTRY_A;
               r_op_valid <= 1'b0;
               r_op_a     <= '0;
               r_op_b     <= '0;
            end
            if (i_key_valid && (w_is_digit || w_is_enter || w_is_back)) begin
               r_err <= 1'b1;
            end
         end else if (i_key_valid) begin
            if (w_is_digit) begin
               if (r_count == c_FULL) begin
                  r_err <= 1'b1;
               end else begin
                  r_entry <= w_shift_in;
                  r_count <= r_count + 1'b1;
               end
            end else if (w_is_back) begin
               if (r_count == '0) begin
                  r_err <= 1'b1;
               end else begin
                  r_entry <= w_shift_out;
                  r_count <= r_count - 1'b1;
               end
            end else if (w_is_clear) begin
               if (r_count != '0) begin
                  r_entry <= '0;
                  r_count <= '0;
               end else if (r_state == ST_ENTRY_B) begin
                  // Clear on an empty B buffer backs out operand A too.
                  r_state <= ST_ENTRY_A;
                  r_op_a  <= '0;
               end
            end else if (w_is_enter) begin
               if (r_count == '0) begin
                  r_err <= 1'b1;
               end else if (r_state == ST_ENTRY_A) begin
                  r_op_a  <= r_entry;
                  r_entry <= '0;
                  r_count <= '0;
                  r_state <= ST_ENTRY_B;
               end else begin
                  r_op_b     <= r_entry;
                  r_entry    <= '0;
                  r_count    <= '0;
                  r_state    <= ST_PRESENT;
                  r_op_valid <= 1'b1;
               end
            end
            // D/E/F fall through untouched.
         end
      end
   end

   assign o_op_a        = r_op_a;
   assign o_op_b        = r_op_b;
   assign o_op_valid    = r_op_valid;
   assign o_entry_bcd   = r_entry;
   assign o_entry_count = r_count;
   assign o_phase       = r_state;
   assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_entry_ctrl                                          |
// | Purpose  : Self-checking bench for keypad_entry_ctrl (DIGITS=3,          |
// |            TIMEOUT=16): per-cycle vector table through a scoreboard,     |
// |            plus hand sequences for timeout and reset in PRESENT.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_keypad_entry_ctrl;

   localparam int DIGITS  = 3;
   localparam int TIMEOUT = 16;
   localparam int NVEC    = 41;

   logic        clk;
   logic        rst_n;
   logic [3:0]  key_value;
   logic        key_valid;
   logic        op_ready;
   logic [11:0] op_a;
   logic [11:0] op_b;
   logic        op_valid;
   logic [11:0] entry_bcd;
   logic [1:0]  entry_count;
   logic [1:0]  phase;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic        kv;
      logic [3:0]  key;
      logic        rdy;
      logic [1:0]  ph;
      logic [11:0] bcd;
      logic [1:0]  cnt;
      logic        err;
      logic        ov;
      logic [11:0] a;
      logic [11:0] b;
   } vec_t;

   vec_t tbl [NVEC];
   vec_t sb [$];

   keypad_entry_ctrl #(
      .DIGITS  (DIGITS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_key_value   (key_value),
      .i_key_valid   (key_valid),
      .o_op_a        (op_a),
      .o_op_b        (op_b),
      .o_op_valid    (op_valid),
      .i_op_ready    (op_ready),
      .o_entry_bcd   (entry_bcd),
      .o_entry_count (entry_count),
      .o_phase       (phase),
      .o_err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic kv, input logic [3:0] key, input logic rdy,
                               input logic [1:0] ph, input logic [11:0] bcd,
                               input logic [1:0] cnt, input logic e, input logic ov,
                               input logic [11:0] a, input logic [11:0] b);
      vec_t v;
      v.kv = kv; v.key = key; v.rdy = rdy; v.ph = ph; v.bcd = bcd;
      v.cnt = cnt; v.err = e; v.ov = ov; v.a = a; v.b = b;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic kv, input logic [3:0] key, input logic rdy);
      @(negedge clk);
      key_valid = kv;
      key_value = key;
      op_ready  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      vec_t e;

      //             kv key   rdy  ph    bcd      cnt  er ov a        b
      tbl[0]  = mk(1, 4'h1, 0, 2'd0, 12'h001, 2'd1, 0, 0, 12'h000, 12'h000);
      tbl[1]  = mk(1, 4'h2, 0, 2'd0, 12'h012, 2'd2, 0, 0, 12'h000, 12'h000);
      tbl[2]  = mk(1, 4'hA, 0, 2'd1, 12'h000, 2'd0, 0, 0, 12'h012, 12'h000);
      tbl[3]  = mk(1, 4'h4, 0, 2'd1, 12'h004, 2'd1, 0, 0, 12'h012, 12'h000);
      tbl[4]  = mk(1, 4'h5, 0, 2'd1, 12'h045, 2'd2, 0, 0, 12'h012, 12'h000);
      tbl[5]  = mk(1, 4'h6, 0, 2'd1, 12'h456, 2'd3, 0, 0, 12'h012, 12'h000);
      tbl[6]  = mk(1, 4'hA, 0, 2'd2, 12'h000, 2'd0, 0, 1, 12'h012, 12'h456);
      tbl[7]  = mk(0, 4'h0, 0, 2'd2, 12'h000, 2'd0, 0, 1, 12'h012, 12'h456);
      tbl[8]  = mk(0, 4'h0, 0, 2'd2, 12'h000, 2'd0, 0, 1, 12'h012, 12'h456);
      tbl[9]  = mk(1, 4'h7, 0, 2'd2, 12'h000, 2'd0, 1, 1, 12'h012, 12'h456);
      tbl[10] = mk(0, 4'h0, 1, 2'd0, 12'h000, 2'd0, 0, 0, 12'h012, 12'h456);
      tbl[11] = mk(1, 4'h7, 0, 2'd0, 12'h007, 2'd1, 0, 0, 12'h012, 12'h456);
      tbl[12] = mk(1, 4'h8, 0, 2'd0, 12'h078, 2'd2, 0, 0, 12'h012, 12'h456);
      tbl[13] = mk(1, 4'h9, 0, 2'd0, 12'h789, 2'd3, 0, 0, 12'h012, 12'h456);
      tbl[14] = mk(1, 4'h5, 0, 2'd0, 12'h789, 2'd3, 1, 0, 12'h012, 12'h456);
      tbl[15] = mk(0, 4'h0, 0, 2'd0, 12'h789, 2'd3, 0, 0, 12'h012, 12'h456);
      tbl[16] = mk(1, 4'hB, 0, 2'd0, 12'h078, 2'd2, 0, 0, 12'h012, 12'h456);
      tbl[17] = mk(1, 4'hC, 0, 2'd0, 12'h000, 2'd0, 0, 0, 12'h012, 12'h456);
      tbl[18] = mk(1, 4'hA, 0, 2'd0, 12'h000, 2'd0, 1, 0, 12'h012, 12'h456);
      tbl[19] = mk(0, 4'h0, 0, 2'd0, 12'h000, 2'd0, 0, 0, 12'h012, 12'h456);
      tbl[20] = mk(1, 4'hB, 0, 2'd0, 12'h000, 2'd0, 1, 0, 12'h012, 12'h456);
      tbl[21] = mk(1, 4'hD, 0, 2'd0, 12'h000, 2'd0, 0, 0, 12'h012, 12'h456);
      tbl[22] = mk(1, 4'hC, 0, 2'd0, 12'h000, 2'd0, 0, 0, 12'h012, 12'h456);
      tbl[23] = mk(1, 4'h3, 0, 2'd0, 12'h003, 2'd1, 0, 0, 12'h012, 12'h456);
      tbl[24] = mk(1, 4'hA, 0, 2'd1, 12'h000, 2'd0, 0, 0, 12'h003, 12'h456);
      tbl[25] = mk(1, 4'hC, 0, 2'd0, 12'h000, 2'd0, 0, 0, 12'h000, 12'h456);
      tbl[26] = mk(1, 4'h1, 0, 2'd0, 12'h001, 2'd1, 0, 0, 12'h000, 12'h456);
      tbl[27] = mk(1, 4'hA, 0, 2'd1, 12'h000, 2'd0, 0, 0, 12'h001, 12'h456);
      tbl[28] = mk(1, 4'h2, 0, 2'd1, 12'h002, 2'd1, 0, 0, 12'h001, 12'h456);
      tbl[29] = mk(1, 4'hA, 0, 2'd2, 12'h000, 2'd0, 0, 1, 12'h001, 12'h002);
      tbl[30] = mk(1, 4'hC, 1, 2'd0, 12'h000, 2'd0, 0, 0, 12'h001, 12'h002);
      tbl[31] = mk(1, 4'h5, 0, 2'd0, 12'h005, 2'd1, 0, 0, 12'h001, 12'h002);
      tbl[32] = mk(1, 4'hA, 0, 2'd1, 12'h000, 2'd0, 0, 0, 12'h005, 12'h002);
      tbl[33] = mk(1, 4'h6, 0, 2'd1, 12'h006, 2'd1, 0, 0, 12'h005, 12'h002);
      tbl[34] = mk(1, 4'hA, 0, 2'd2, 12'h000, 2'd0, 0, 1, 12'h005, 12'h006);
      tbl[35] = mk(1, 4'hC, 0, 2'd0, 12'h000, 2'd0, 0, 0, 12'h000, 12'h000);
      tbl[36] = mk(1, 4'h1, 1, 2'd0, 12'h001, 2'd1, 0, 0, 12'h000, 12'h000);
      tbl[37] = mk(1, 4'hA, 1, 2'd1, 12'h000, 2'd0, 0, 0, 12'h001, 12'h000);
      tbl[38] = mk(1, 4'h9, 1, 2'd1, 12'h009, 2'd1, 0, 0, 12'h001, 12'h000);
      tbl[39] = mk(1, 4'hA, 1, 2'd2, 12'h000, 2'd0, 0, 1, 12'h001, 12'h009);
      tbl[40] = mk(0, 4'h0, 1, 2'd0, 12'h000, 2'd0, 0, 0, 12'h001, 12'h009);

      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_value = 4'h0;
      op_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_phase", 32'(phase), 32'd0);
      chk("reset_bcd",   32'(entry_bcd), 32'd0);
      chk("reset_count", 32'(entry_count), 32'd0);
      chk("reset_valid", 32'(op_valid), 32'd0);
      chk("reset_err",   32'(err), 32'd0);
      chk("reset_opa",   32'(op_a), 32'd0);
      chk("reset_opb",   32'(op_b), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         key_valid = tbl[i].kv;
         key_value = tbl[i].key;
         op_ready  = tbl[i].rdy;
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("row%0d_phase", i), 32'(phase), 32'(e.ph));
         chk($sformatf("row%0d_bcd", i),   32'(entry_bcd), 32'(e.bcd));
         chk($sformatf("row%0d_count", i), 32'(entry_count), 32'(e.cnt));
         chk($sformatf("row%0d_err", i),   32'(err), 32'(e.err));
         chk($sformatf("row%0d_valid", i), 32'(op_valid), 32'(e.ov));
         chk($sformatf("row%0d_opa", i),   32'(op_a), 32'(e.a));
         chk($sformatf("row%0d_opb", i),   32'(op_b), 32'(e.b));
      end

      // Timeout with a partial entry in ENTRY_A.
      step(1'b1, 4'h3, 1'b0);
      idle(15);
      chk("tmo_a_pre_count", 32'(entry_count), 32'd1);
      chk("tmo_a_pre_bcd",   32'(entry_bcd), 32'h003);
      idle(1);
      chk("tmo_a_count", 32'(entry_count), 32'd0);
      chk("tmo_a_bcd",   32'(entry_bcd), 32'd0);
      chk("tmo_a_phase", 32'(phase), 32'd0);
      chk("tmo_a_err",   32'(err), 32'd0);

      // Timeout in ENTRY_B with an empty buffer discards operand A.
      step(1'b1, 4'h4, 1'b0);
      step(1'b1, 4'hA, 1'b0);
      chk("tmo_b_enter_phase", 32'(phase), 32'd1);
      chk("tmo_b_enter_opa",   32'(op_a), 32'h004);
      idle(15);
      chk("tmo_b_pre_phase", 32'(phase), 32'd1);
      idle(1);
      chk("tmo_b_phase", 32'(phase), 32'd0);
      chk("tmo_b_opa",   32'(op_a), 32'd0);
      chk("tmo_b_opb",   32'(op_b), 32'h009);
      chk("tmo_b_err",   32'(err), 32'd0);

      // A key in the would-be timeout cycle is taken and restarts the count.
      step(1'b1, 4'h3, 1'b0);
      idle(15);
      step(1'b1, 4'h5, 1'b0);
      chk("tmo_key_bcd",   32'(entry_bcd), 32'h035);
      chk("tmo_key_count", 32'(entry_count), 32'd2);
      idle(15);
      chk("tmo_key_hold_count", 32'(entry_count), 32'd2);
      idle(1);
      chk("tmo_key_late_count", 32'(entry_count), 32'd0);

      // Asynchronous reset while presenting a pair.
      step(1'b1, 4'h1, 1'b0);
      step(1'b1, 4'hA, 1'b0);
      step(1'b1, 4'h2, 1'b0);
      step(1'b1, 4'hA, 1'b0);
      chk("rstp_valid_pre", 32'(op_valid), 32'd1);
      chk("rstp_phase_pre", 32'(phase), 32'd2);
      @(negedge clk);
      key_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstp_valid", 32'(op_valid), 32'd0);
      chk("rstp_phase", 32'(phase), 32'd0);
      chk("rstp_opa",   32'(op_a), 32'd0);
      chk("rstp_opb",   32'(op_b), 32'd0);
      chk("rstp_bcd",   32'(entry_bcd), 32'd0);
      chk("rstp_count", 32'(entry_count), 32'd0);
      chk("rstp_err",   32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("rstp_rel_phase", 32'(phase), 32'd0);
      chk("rstp_rel_valid", 32'(op_valid), 32'd0);
      step(1'b1, 4'h7, 1'b0);
      chk("rstp_rel_bcd", 32'(entry_bcd), 32'h007);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequences operand entry from the 4x4 keypad front end: it consumes the decoded, single-cycle `key_valid`/`key_value` event stream and assembles two BCD operands of up to `DIGITS` digits each. It handles ENTER, backspace, clear, overflow and inactivity timeout. Completed operand pairs go to the downstream arithmetic/display stage over a valid/ready handshake.

## Interface
- `DIGITS`, 3, maximum BCD digits per operand (1..8)
- `TIMEOUT`, 50_000_000, clk cycles without `key_valid` before a partial entry is discarded; 0 disables the timeout
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `key_value`  in  4  decoded key code: 0-9 digit, A ENTER, B backspace, C clear, D/E/F ignored
- `key_valid`  in  1  one-cycle strobe qualifying `key_value`
- `op_a`  out  4*DIGITS  latched operand A, BCD, least significant digit in [3:0]
- `op_b`  out  4*DIGITS  latched operand B, BCD
- `op_valid`  out  1  operand pair available
- `op_ready`  in  1  downstream accepts the pair
- `entry_bcd`  out  4*DIGITS  digits currently being typed, for display
- `entry_count`  out  $clog2(DIGITS+1)  number of digits in `entry_bcd`
- `phase`  out  2  00 ENTRY_A, 01 ENTRY_B, 10 PRESENT
- `err`  out  1  one-cycle pulse flagging a rejected key

## Operation
- States: ENTRY_A, ENTRY_B and PRESENT. `phase` encodes the current state directly.
- Key events are acted on only in the cycle `key_valid`=1. `key_value` is ignored at all other times.
- Digit key (0-9) in either ENTRY state:
  - If `entry_count`<DIGITS: `entry_bcd` <= {entry_bcd[4*DIGITS-5:0], digit} and `entry_count`++.
  - If `entry_count`==DIGITS: the key is dropped and `err` pulses.
- B (backspace) in either ENTRY state:
  - If `entry_count`>0: `entry_bcd` <= {4'h0, entry_bcd[4*DIGITS-1:4]} and `entry_count`--.
  - If `entry_count`==0: no change and `err` pulses.
- C (clear) in either ENTRY state:
  - If `entry_count`>0: `entry_bcd`=0 and `entry_count`=0; state is unchanged.
  - If `entry_count`==0 in ENTRY_B: go to ENTRY_A and zero `op_a`, which discards operand A.
  - If `entry_count`==0 in ENTRY_A: no operation, and `err` does not pulse.
- A (ENTER) in either ENTRY state:
  - If `entry_count`==0: `err` pulses and state is unchanged.
  - In ENTRY_A otherwise: `op_a` <= `entry_bcd`, the entry buffer clears, and the state goes to ENTRY_B.
  - In ENTRY_B otherwise: `op_b` <= `entry_bcd`, the entry buffer clears, the state goes to PRESENT, and `op_valid` is set to 1.
- D/E/F: ignored in every state, with no `err`.
- PRESENT:
  - `op_valid` holds at 1, and `op_a`/`op_b` are stable, until `op_valid`&&`op_ready` is sampled.
  - On that handshake, state goes to ENTRY_A and `op_valid` goes to 0. `op_a`/`op_b` keep their values until overwritten.
  - Digit, A and B keys are dropped with an `err` pulse.
  - C aborts: go to ENTRY_A, `op_valid`=0, and zero `op_a`/`op_b`.
  - If C and `op_ready` occur in the same cycle, the handshake wins: the transfer completes and `op_a`/`op_b` are retained.
- Timeout:
  - An idle counter resets on every `key_valid` and counts only in ENTRY_A/ENTRY_B.
  - When it reaches TIMEOUT-1 and either `entry_count`>0 or the state is ENTRY_B: return to ENTRY_A, clear `entry_bcd`, `entry_count` and `op_a`, and do not pulse `err`.
  - If `key_valid` occurs in the timeout cycle, the key wins and the counter restarts.
  - PRESENT never times out.
- Width rule: the counter is sized $clog2(TIMEOUT+1). No arithmetic is done on the BCD digits; they are stored as entered.

## Timing
- Reset values: `phase`=ENTRY_A, and `op_a`, `op_b`, `entry_bcd`, `entry_count`, `op_valid`, `err` and the idle counter all 0.
- Reset asserted mid-entry or in PRESENT takes effect immediately and aborts any pending handshake.
- Latency:
  - Key strobe at edge n: all registered outputs (`entry_*`, `op_*`, `phase`, `err`) reflect the key after edge n.
  - `err` is high for exactly that one cycle.
- `op_valid` rises one cycle after the ENTER strobe that completes B. It never drops without a handshake, except for C or reset.
- The handshake completes on the edge where `op_valid`=1 and `op_ready`=1. `op_valid` is 0 in the following cycle.
- `op_ready` held high continuously is legal: each completed pair is transferred after being presented for exactly one cycle.
- Back-to-back key strobes on consecutive cycles are processed in order, one per cycle.

## Test plan
- DIGITS=3, keys 1,2,A,4,5,6,A with `op_ready`=0 -> `op_a`=12'h012, `op_b`=12'h456, `phase`=10, `op_valid`=1 and held; raise `op_ready` -> next cycle `op_valid`=0, `phase`=00.
- Keys 7,8,9,5 -> `entry_bcd`=12'h789, `entry_count`=3, `err` pulses once on the 5; then B -> 12'h078, count 2.
- A with an empty buffer -> `err` 1-cycle pulse, `phase` stays 00; B with an empty buffer -> `err`, no change.
- In ENTRY_B with an empty buffer, key C -> `phase`=00, `op_a`=0; in PRESENT, C with `op_ready`=1 in the same cycle -> transfer completes and `op_a`/`op_b` are retained.
- TIMEOUT=16, key 3 then no keys for 16 cycles -> `entry_count`=0, `entry_bcd`=0, `phase`=00, no `err`; a key strobe in the 16th cycle is taken instead.
- Assert `rst_n` low while in PRESENT -> all outputs 0 immediately, and `phase`=00 after release.
